// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the 2x2 / stride-2 pooling sequencer.
//   - pool_state_e : sequencer state (IDLE -> RUN -> DONE -> IDLE)
//   - rf_wr_src_e  : register-file write data select (raw element / pooled partial)
//   - elem_kind_e  : role of an element inside its 2x2 pooling window
//   - POOL_WIN / POOL_STRIDE : window edge and stride (both 2)
//   - classify_elem() : maps the row/column parity to the element role
// -----------------------------------------------------------------------------
package pool_pkg;

   localparam int POOL_WIN    = 2;
   localparam int POOL_STRIDE = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } pool_state_e;

   typedef enum logic {
      WR_SYS  = 1'b0,   // store the raw sys_out element
      WR_POOL = 1'b1    // store the pooling unit output (partial result)
   } rf_wr_src_e;

   // EL_STORE : top-left of a window, opens the partial result
   // EL_ACCUM : top-right / bottom-left, folds into the partial result
   // EL_FINAL : bottom-right, completes the window
   typedef enum logic [1:0] {
      EL_STORE = 2'd0,
      EL_ACCUM = 2'd1,
      EL_FINAL = 2'd2
   } elem_kind_e;

   function automatic elem_kind_e classify_elem(input logic r_odd, input logic c_odd);
      if (!r_odd && !c_odd) begin
         return EL_STORE;
      end else if (r_odd && c_odd) begin
         return EL_FINAL;
      end else begin
         return EL_ACCUM;
      end
   endfunction

endpackage

// File: rtl/pool_ctrl.sv
// -----------------------------------------------------------------------------
// pool_ctrl
// Sequencer for the 2x2 / stride-2 pooling datapath. Consumes the row-major
// element stream of the systolic array (one element per in_valid cycle),
// keeps one partial result per output column in the register file, and flags
// every completed pooled element with its output coordinates.
//
// Ports
//   clk, nrst        clock, asynchronous active-low reset
//   start            begin a pass (sampled in IDLE only)
//   cfg_w, cfg_h     input map columns / rows, latched on an accepted start
//   in_valid         sys_out carries a valid element this cycle
//   pool_en          pooling unit enable
//   x_sel            pooling in1 mux: 1 = sys_out, 0 = pooling feedback
//   rf_wr            register-file write strobe
//   rf_wr_src        write data select (WR_SYS / WR_POOL)
//   rf_wr_addr       register-file write address
//   rf_rd_addr       register-file read address (feeds pooling in2)
//   out_valid        pooling output is a final pooled element
//   out_row, out_col coordinates of that pooled element
//   busy             pass in progress
//   done             one-cycle pulse after the last element of a pass
// -----------------------------------------------------------------------------
module pool_ctrl
   import pool_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DIM_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic [DIM_WIDTH-1:0]  cfg_w,
   input  logic [DIM_WIDTH-1:0]  cfg_h,
   input  logic                  in_valid,
   output logic                  pool_en,
   output logic                  x_sel,
   output logic                  rf_wr,
   output logic                  rf_wr_src,
   output logic [ADDR_WIDTH-1:0] rf_wr_addr,
   output logic [ADDR_WIDTH-1:0] rf_rd_addr,
   output logic                  out_valid,
   output logic [DIM_WIDTH-2:0]  out_row,
   output logic [DIM_WIDTH-2:0]  out_col,
   output logic                  busy,
   output logic                  done
);

   localparam logic [DIM_WIDTH-1:0] ONE       = DIM_WIDTH'(1);
   // Clearing bit 0 drops an odd trailing row/column that cannot fill a window.
   localparam logic [DIM_WIDTH-1:0] EVEN_MASK = ~ONE;

   pool_state_e          state_q, state_d;
   logic [DIM_WIDTH-1:0] w_eff_q, w_eff_d;
   logic [DIM_WIDTH-1:0] h_eff_q, h_eff_d;
   logic [DIM_WIDTH-1:0] r_q, r_d;
   logic [DIM_WIDTH-1:0] c_q, c_d;

   logic [DIM_WIDTH-1:0] cfg_w_eff;
   logic [DIM_WIDTH-1:0] cfg_h_eff;
   logic                 accept_start;
   logic                 consume;
   logic                 last_col;
   logic                 last_row;
   logic                 last_elem;
   elem_kind_e           kind;

   assign cfg_w_eff    = cfg_w & EVEN_MASK;
   assign cfg_h_eff    = cfg_h & EVEN_MASK;
   assign accept_start = (state_q == IDLE) && start;
   assign consume      = (state_q == RUN) && in_valid;

   // In RUN both effective dimensions are at least 2, so the minus-one
   // compares never see an underflowed bound.
   assign last_col     = (c_q == (w_eff_q - ONE));
   assign last_row     = (r_q == (h_eff_q - ONE));
   assign last_elem    = last_col && last_row;

   assign kind         = classify_elem(r_q[0], c_q[0]);

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // Configuration and position counters
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         w_eff_q <= '0;
         h_eff_q <= '0;
         r_q     <= '0;
         c_q     <= '0;
      end else begin
         w_eff_q <= w_eff_d;
         h_eff_q <= h_eff_d;
         r_q     <= r_d;
         c_q     <= c_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               // An empty effective map has nothing to pool: finish at once.
               if ((cfg_w_eff == '0) || (cfg_h_eff == '0)) begin
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (consume && last_elem) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Counter / configuration update
   // ---------------------------------------------------------------------
   always_comb begin
      w_eff_d = w_eff_q;
      h_eff_d = h_eff_q;
      r_d     = r_q;
      c_d     = c_q;
      if (accept_start) begin
         w_eff_d = cfg_w_eff;
         h_eff_d = cfg_h_eff;
         r_d     = '0;
         c_d     = '0;
      end else if (consume) begin
         if (last_col) begin
            c_d = '0;
            // Counters return to zero after the final element so the
            // address outputs rest at 0 between passes.
            r_d = last_row ? '0 : (r_q + ONE);
         end else begin
            c_d = c_q + ONE;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: combinational from the registered position and live in_valid,
   // so the controls line up with the element on sys_out in the same cycle.
   // Dropping bit 0 of a position divides it by the stride of 2.
   // ---------------------------------------------------------------------
   always_comb begin
      pool_en    = 1'b0;
      x_sel      = 1'b0;
      rf_wr      = 1'b0;
      rf_wr_src  = WR_SYS;
      out_valid  = 1'b0;
      out_row    = '0;
      out_col    = '0;
      // One register-file slot per output column; the address follows the
      // pending element even while the stream stalls.
      rf_wr_addr = c_q[ADDR_WIDTH:1];
      rf_rd_addr = c_q[ADDR_WIDTH:1];
      busy       = (state_q == RUN);
      done       = (state_q == DONE);
      if (consume) begin
         unique case (kind)
            EL_STORE: begin
               rf_wr     = 1'b1;
               rf_wr_src = WR_SYS;
            end
            EL_ACCUM: begin
               pool_en   = 1'b1;
               x_sel     = 1'b1;
               rf_wr     = 1'b1;
               rf_wr_src = WR_POOL;
            end
            EL_FINAL: begin
               // The completed window leaves on the pooling output; it is
               // not written back.
               pool_en   = 1'b1;
               x_sel     = 1'b1;
               out_valid = 1'b1;
               out_row   = r_q[DIM_WIDTH-1:1];
               out_col   = c_q[DIM_WIDTH-1:1];
            end
            default: begin
               rf_wr = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pool_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pool_ctrl
// Self-checking bench for pool_ctrl. Every scenario drives a pass, records the
// observed controls cycle by cycle, and compares them with a reference trace
// built from the pooling rules: element k of a pass sits at
// (r, c) = (k / w_eff, k % w_eff), and its role follows from the parities.
// -----------------------------------------------------------------------------
module tb_pool_ctrl;
   import pool_pkg::*;

   localparam int AW = 5;
   localparam int DW = 8;
   localparam int RW = DW - 1;
   localparam int MAX_CYC = 4000;

   logic          clk = 1'b0;
   logic          nrst;
   logic          start;
   logic [DW-1:0] cfg_w;
   logic [DW-1:0] cfg_h;
   logic          in_valid;
   logic          pool_en;
   logic          x_sel;
   logic          rf_wr;
   logic          rf_wr_src;
   logic [AW-1:0] rf_wr_addr;
   logic [AW-1:0] rf_rd_addr;
   logic          out_valid;
   logic [RW-1:0] out_row;
   logic [RW-1:0] out_col;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   pool_ctrl #(
      .ADDR_WIDTH (AW),
      .DIM_WIDTH  (DW)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .start      (start),
      .cfg_w      (cfg_w),
      .cfg_h      (cfg_h),
      .in_valid   (in_valid),
      .pool_en    (pool_en),
      .x_sel      (x_sel),
      .rf_wr      (rf_wr),
      .rf_wr_src  (rf_wr_src),
      .rf_wr_addr (rf_wr_addr),
      .rf_rd_addr (rf_rd_addr),
      .out_valid  (out_valid),
      .out_row    (out_row),
      .out_col    (out_col),
      .busy       (busy),
      .done       (done)
   );

   // Per-cycle observation. Fields the design leaves unconstrained are
   // masked: write source only matters on a write, addresses only in RUN,
   // coordinates only with out_valid.
   typedef struct packed {
      logic          busy;
      logic          done;
      logic          pool_en;
      logic          x_sel;
      logic          rf_wr;
      logic          wr_src;
      logic [AW-1:0] wr_addr;
      logic [AW-1:0] rd_addr;
      logic          out_valid;
      logic [RW-1:0] out_row;
      logic [RW-1:0] out_col;
   } obs_t;

   obs_t obs_q[$];
   obs_t exp_q[$];
   bit   iv_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   done_extra;
   bit   timed_out;

   function automatic obs_t sample_now();
      obs_t o;
      o           = '0;
      o.busy      = busy;
      o.done      = done;
      o.pool_en   = pool_en;
      o.x_sel     = x_sel;
      o.rf_wr     = rf_wr;
      o.wr_src    = rf_wr ? rf_wr_src : 1'b0;
      o.wr_addr   = busy ? rf_wr_addr : '0;
      o.rd_addr   = busy ? rf_rd_addr : '0;
      o.out_valid = out_valid;
      o.out_row   = out_valid ? out_row : '0;
      o.out_col   = out_valid ? out_col : '0;
      return o;
   endfunction

   function automatic logic [30:0] all_outputs();
      return {pool_en, x_sel, rf_wr, rf_wr_src, rf_wr_addr, rf_rd_addr,
              out_valid, out_row, out_col, busy, done};
   endfunction

   // Reference trace from the recorded valid pattern: stalls keep the
   // pending element's address with every strobe low; once all
   // w_eff*h_eff elements are in, the next cycle is the done pulse.
   task automatic build_expected(input int w, input int h);
      int we;
      int he;
      int total;
      int k;
      int r;
      int c;
      obs_t e;
      we    = w & ~1;
      he    = h & ~1;
      total = we * he;
      k     = 0;
      exp_q.delete();
      for (int i = 0; i < iv_q.size(); i++) begin
         e = '0;
         if (k == total) begin
            e.done = 1'b1;
            exp_q.push_back(e);
            break;
         end
         r         = k / we;
         c         = k % we;
         e.busy    = 1'b1;
         e.wr_addr = AW'(c / 2);
         e.rd_addr = AW'(c / 2);
         if (iv_q[i]) begin
            if ((r % 2 == 0) && (c % 2 == 0)) begin
               e.rf_wr  = 1'b1;
               e.wr_src = 1'b0;
            end else if ((r % 2 == 1) && (c % 2 == 1)) begin
               e.pool_en   = 1'b1;
               e.x_sel     = 1'b1;
               e.out_valid = 1'b1;
               e.out_row   = RW'(r / 2);
               e.out_col   = RW'(c / 2);
            end else begin
               e.pool_en = 1'b1;
               e.x_sel   = 1'b1;
               e.rf_wr   = 1'b1;
               e.wr_src  = 1'b1;
            end
            k++;
         end
         exp_q.push_back(e);
      end
   endtask

   // Drives one pass. mode 0: in_valid held high, 1: toggling 1,0,1,0...,
   // 2: random. noise: random start and cfg values while the pass runs.
   task automatic run_pass(input int w, input int h, input int mode, input bit noise);
      bit   iv;
      obs_t o;
      iv_q.delete();
      obs_q.delete();
      timed_out  = 1'b1;
      done_extra = 0;
      @(negedge clk);
      start    = 1'b1;
      cfg_w    = DW'(w);
      cfg_h    = DW'(h);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < MAX_CYC; i++) begin
         @(negedge clk);
         case (mode)
            0:       iv = 1'b1;
            1:       iv = (i % 2 == 0);
            default: iv = ($urandom_range(0, 2) != 0);
         endcase
         in_valid = iv;
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            cfg_w = DW'($urandom);
            cfg_h = DW'($urandom);
         end
         #1;
         o = sample_now();
         iv_q.push_back(iv);
         obs_q.push_back(o);
         if (o.done) begin
            timed_out = 1'b0;
            break;
         end
      end
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         start    = 1'b0;
         in_valid = 1'($urandom_range(0, 1));
         #1;
         if (done || busy) done_extra++;
      end
      in_valid = 1'b0;
      build_expected(w, h);
      $display("pass w=%0d h=%0d mode=%0d noise=%0d cycles=%0d", w, h, mode, noise, obs_q.size());
   endtask

   task automatic test_reset();
      nrst     = 1'b0;
      start    = 1'b0;
      cfg_w    = '0;
      cfg_h    = '0;
      in_valid = 1'b0;
      #12;
      n_checks++;
      if (all_outputs() !== '0) $display("FAIL reset_outputs got %h want 0", all_outputs());
      else n_pass++;
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (all_outputs() !== '0) $display("FAIL post_reset_idle got %h want 0", all_outputs());
      else n_pass++;
   endtask

   task automatic test_idle_ignores();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start    = 1'b0;
         in_valid = 1'($urandom_range(0, 1));
         #1;
         n_checks++;
         if ({busy, done, pool_en, x_sel, rf_wr, out_valid} !== 6'b0)
            $display("FAIL idle_strobes cycle %0d got %b want 000000", i,
                     {busy, done, pool_en, x_sel, rf_wr, out_valid});
         else n_pass++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_full_4x4();
      int ov_pos[$];
      int ov_rc[$];
      int want_pos[4] = '{5, 7, 13, 15};
      int want_rc[4]  = '{0, 1, 16, 17};
      int n_wr;
      int n_busy;
      run_pass(4, 4, 0, 1'b0);
      n_checks++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL full4x4_len got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL full4x4_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
      n_wr   = 0;
      n_busy = 0;
      foreach (obs_q[i]) begin
         if (obs_q[i].out_valid) begin
            ov_pos.push_back(i);
            ov_rc.push_back(int'(obs_q[i].out_row) * 16 + int'(obs_q[i].out_col));
         end
         if (obs_q[i].rf_wr) n_wr++;
         if (obs_q[i].busy) n_busy++;
      end
      n_checks++;
      if (ov_pos.size() !== 4) $display("FAIL full4x4_ov_count got %0d want 4", ov_pos.size());
      else n_pass++;
      for (int i = 0; i < 4 && i < ov_pos.size(); i++) begin
         n_checks++;
         if ((ov_pos[i] !== want_pos[i]) || (ov_rc[i] !== want_rc[i]))
            $display("FAIL full4x4_ov%0d got elem %0d rc %0d want elem %0d rc %0d",
                     i, ov_pos[i] + 1, ov_rc[i], want_pos[i] + 1, want_rc[i]);
         else n_pass++;
      end
      n_checks++;
      if (n_wr !== 12) $display("FAIL full4x4_rf_wr_count got %0d want 12", n_wr);
      else n_pass++;
      n_checks++;
      if (n_busy !== 16) $display("FAIL full4x4_busy_cycles got %0d want 16", n_busy);
      else n_pass++;
      n_checks++;
      if (timed_out || done_extra !== 0) $display("FAIL full4x4_done got timeout=%0d extra=%0d want 0 0", timed_out, done_extra);
      else n_pass++;
   endtask

   task automatic test_toggle_4x4();
      run_pass(4, 4, 1, 1'b0);
      n_checks++;
      // 31 RUN cycles, then the done cycle.
      if (obs_q.size() !== 32) $display("FAIL toggle_len got %0d want 32", obs_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL toggle_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (timed_out || done_extra !== 0) $display("FAIL toggle_done got timeout=%0d extra=%0d want 0 0", timed_out, done_extra);
      else n_pass++;
   endtask

   task automatic test_odd_dims();
      int n_ov;
      run_pass(5, 3, 0, 1'b0);
      n_checks++;
      if (obs_q.size() !== 9) $display("FAIL odd_len got %0d want 9", obs_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL odd_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
      n_ov = 0;
      foreach (obs_q[i]) if (obs_q[i].out_valid) n_ov++;
      n_checks++;
      if (n_ov !== 2) $display("FAIL odd_ov_count got %0d want 2", n_ov);
      else n_pass++;
   endtask

   task automatic test_zero_dim();
      int dims[2][2] = '{'{0, 4}, '{4, 1}};
      int n_wr;
      for (int t = 0; t < 2; t++) begin
         run_pass(dims[t][0], dims[t][1], 2, 1'b0);
         n_wr = 0;
         foreach (obs_q[i]) if (obs_q[i].rf_wr || obs_q[i].busy) n_wr++;
         n_checks++;
         if ((obs_q.size() !== 1) || !obs_q[0].done)
            $display("FAIL zero_dim%0d_done got len %0d done %0d want len 1 done 1",
                     t, obs_q.size(), (obs_q.size() > 0) ? obs_q[0].done : 1'b0);
         else n_pass++;
         n_checks++;
         if ((n_wr !== 0) || (done_extra !== 0))
            $display("FAIL zero_dim%0d_quiet got wr/busy %0d extra %0d want 0 0", t, n_wr, done_extra);
         else n_pass++;
      end
   endtask

   task automatic test_start_ignored();
      run_pass(2, 2, 2, 1'b1);
      n_checks++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL noise_len got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL noise_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (timed_out || done_extra !== 0) $display("FAIL noise_single_done got timeout=%0d extra=%0d want 0 0", timed_out, done_extra);
      else n_pass++;
   endtask

   task automatic test_random_passes();
      int w;
      int h;
      int bad;
      for (int p = 0; p < 7; p++) begin
         if (p == 6) begin
            w = 64;
            h = 2;
         end else begin
            w = $urandom_range(0, 12);
            h = $urandom_range(0, 9);
         end
         run_pass(w, h, 2, 1'b0);
         n_checks++;
         if (obs_q.size() !== exp_q.size()) $display("FAIL rand%0d_len got %0d want %0d", p, obs_q.size(), exp_q.size());
         else n_pass++;
         bad = -1;
         for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if ((obs_q[i] !== exp_q[i]) && (bad < 0)) bad = i;
         end
         n_checks++;
         if (bad >= 0) $display("FAIL rand%0d_trace w=%0d h=%0d cycle %0d got %h want %h", p, w, h, bad, obs_q[bad], exp_q[bad]);
         else n_pass++;
         n_checks++;
         if (timed_out || done_extra !== 0) $display("FAIL rand%0d_done got timeout=%0d extra=%0d want 0 0", p, timed_out, done_extra);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_pass();
      int n_done;
      @(negedge clk);
      start    = 1'b1;
      cfg_w    = DW'(4);
      cfg_h    = DW'(4);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b1;
      nrst     = 1'b0;
      #1;
      n_checks++;
      if (all_outputs() !== '0) $display("FAIL midreset_outputs got %h want 0", all_outputs());
      else n_pass++;
      n_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b1;
         #1;
         if (done || busy) n_done++;
      end
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      nrst     = 1'b1;
      #1;
      if (done || busy) n_done++;
      @(negedge clk);
      #1;
      if (done || busy) n_done++;
      n_checks++;
      if (n_done !== 0) $display("FAIL midreset_no_done got %0d busy/done cycles want 0", n_done);
      else n_pass++;
      run_pass(2, 2, 0, 1'b0);
      n_checks++;
      if (obs_q.size() !== exp_q.size()) $display("FAIL midreset_len got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL midreset_cycle%0d got %h want %h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if ((obs_q.size() < 4) || !obs_q[3].out_valid || (obs_q[3].out_row !== '0) || (obs_q[3].out_col !== '0))
         $display("FAIL midreset_fourth_ov got len %0d ov %0d want ov 1 at (0,0)", obs_q.size(),
                  (obs_q.size() >= 4) ? obs_q[3].out_valid : 1'b0);
      else n_pass++;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got no finish want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_idle_ignores();
      test_full_4x4();
      test_toggle_4x4();
      test_odd_dims();
      test_zero_dim();
      test_start_ignored();
      test_random_passes();
      test_reset_mid_pass();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
